serial_set_period_tx: RTL and testbench
=======================================

SERIAL_SET_PERIOD_TX -- requirements
Module: serial_set_period_tx

Interface
REQ-001 SHALL have parameter TARGET_PERIOD, default 10, meaning clocks per transmitted bit (f_bit = f_clk / TARGET_PERIOD), legal range >= 2.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning payload bits per frame, legal range >= 1.
REQ-003 SHALL have parameter PREAMBLE_BITS, default 8, meaning alternating lock-in bits per frame; must be even and >= 2.
REQ-004 SHALL have port clk, input, 1, the single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port dataIn, input, DATA_WIDTH, the payload word.
REQ-007 SHALL have port dataValid, input, 1, meaning the payload word is offered.
REQ-008 SHALL have port dataReady, output, 1, meaning the block accepts a word this cycle.
REQ-009 SHALL have port tx, output, 1, the registered serial line.
REQ-010 SHALL have port bitStrobe, output, 1, a one-cycle pulse on the first cycle of every transmitted bit.
REQ-011 SHALL have port busy, output, 1, high while a frame is in progress (any state except IDLE).

Function
REQ-012 SHALL implement the states IDLE, PREAMBLE, START, DATA, PARITY and STOP.
REQ-013 SHALL keep a period counter running 0..TARGET_PERIOD-1 and wrapping to 0; each bit lasts exactly TARGET_PERIOD cycles.
REQ-014 In IDLE, SHALL drive dataReady=1 and tx=0; in all other states, SHALL drive dataReady=0.
REQ-015 On a rising edge sampling dataValid=1 and dataReady=1, SHALL latch dataIn, enter PREAMBLE with period counter 0, and register tx=1 and bitStrobe=1; this gives one-cycle latency from acceptance to the first bit.
REQ-016 PREAMBLE SHALL send PREAMBLE_BITS bits alternating 1,0,1,0..., ending on 0.
REQ-017 START SHALL send two bit periods of 1 as the frame marker (the first repeated level after the preamble).
REQ-018 DATA SHALL send the latched word MSB first, DATA_WIDTH bits.
REQ-019 PARITY SHALL exist only per REQ-028.
REQ-020 STOP SHALL send one bit period of 0, then return to IDLE; bitStrobe SHALL NOT pulse on the IDLE entry.
REQ-021 bitStrobe SHALL be 1 exactly on cycles where the period counter is 0 and the state is not IDLE; tx SHALL change only on those cycles.
REQ-022 Changes to dataIn or dataValid after acceptance SHALL NOT affect the frame in flight.
REQ-023 Back-to-back operation: at least one IDLE cycle separates frames; a word held valid through the frame SHALL be accepted on the first IDLE cycle.
REQ-024 Frame length SHALL be (PREAMBLE_BITS + 2 + DATA_WIDTH + P + 1) x TARGET_PERIOD cycles, where P = 1 with parity and 0 without.

Reset
REQ-025 Asserting rst_n=0 SHALL immediately force state IDLE, period counter 0, tx=0, bitStrobe=0, busy=0 and dataReady=0, independent of clk.
REQ-026 Reset mid-frame SHALL discard the frame with no further bits sent; on the first rising clk edge after rst_n deasserts, SHALL register dataReady=1.
REQ-027 The latched data register SHALL also clear to 0 on reset.

Configuration
REQ-028 With macro SERIAL_SET_PERIOD_TX_PARITY_EN defined, SHALL send one PARITY bit after DATA, equal to the XOR of all data bits (even parity); without it, SHALL go DATA -> STOP directly and include no parity logic.

Verification
REQ-029 Defaults, no parity, send 0xA5 -> tx bits 1,0,1,0,1,0,1,0,1,1,1,0,1,0,0,1,0,1,0, each 10 cycles; busy for 190 cycles; 19 bitStrobe pulses.
REQ-030 Parity enabled, send 0x07 -> parity bit 1 before stop; 200-cycle frame. Send 0xA5 -> parity bit 0.
REQ-031 dataValid held high with 0x3C then 0xC3 -> two frames separated by exactly one IDLE cycle; second payload is 0xC3.
REQ-032 rst_n pulsed low at cycle 57 of a frame -> tx=0 and busy=0 asynchronously; dataReady=1 at the next clk edge after release; no residual bits.
REQ-033 TARGET_PERIOD=2, DATA_WIDTH=1, PREAMBLE_BITS=2, send 1 -> tx 1,0,1,1,1,0 at 2 cycles per bit.
REQ-034 dataIn toggled every cycle after acceptance of 0x5A -> transmitted payload remains 0x5A.

Source files
------------

// File: rtl/serial_set_period_tx.sv
// serial_set_period_tx: fixed-rate serial framer.
// Frame = alternating preamble, two-bit start marker of 1s, payload MSB first,
// optional even-parity bit, one stop bit of 0. Each bit lasts TARGET_PERIOD clocks.
// Optional parity bit enabled by defining SERIAL_SET_PERIOD_TX_PARITY_EN.
module serial_set_period_tx #(
    parameter int TARGET_PERIOD = 10,
    parameter int DATA_WIDTH    = 8,
    parameter int PREAMBLE_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] dataIn,
    input  logic                  dataValid,
    output logic                  dataReady,
    output logic                  tx,
    output logic                  bitStrobe,
    output logic                  busy
);

    localparam int CNT_W    = $clog2(TARGET_PERIOD);
    localparam int MAX_BITS = (PREAMBLE_BITS > DATA_WIDTH) ? PREAMBLE_BITS : DATA_WIDTH;
    localparam int IDX_W    = $clog2(MAX_BITS);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TARGET_PERIOD - 1);
    localparam logic [IDX_W-1:0] PRE_LAST = IDX_W'(PREAMBLE_BITS - 1);
    localparam logic [IDX_W-1:0] DAT_LAST = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, PREAMBLE, START, DATA, PARITY, STOP} state_t;

    state_t                  state, stateNext;
    logic [CNT_W-1:0]        cnt, cntNext;
    logic [IDX_W-1:0]        bitIdx, idxNext;
    logic [DATA_WIDTH-1:0]   shiftReg, shiftNext;
    logic                    txNext, strobeNext, readyNext;
`ifdef SERIAL_SET_PERIOD_TX_PARITY_EN
    logic                    parReg, parNext;
`endif

    assign busy = (state != IDLE);

    // State, counters, payload and registered line outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bitIdx    <= '0;
            shiftReg  <= '0;
            tx        <= 1'b0;
            bitStrobe <= 1'b0;
            dataReady <= 1'b0;
`ifdef SERIAL_SET_PERIOD_TX_PARITY_EN
            parReg    <= 1'b0;
`endif
        end else begin
            state     <= stateNext;
            cnt       <= cntNext;
            bitIdx    <= idxNext;
            shiftReg  <= shiftNext;
            tx        <= txNext;
            bitStrobe <= strobeNext;
            dataReady <= readyNext;
`ifdef SERIAL_SET_PERIOD_TX_PARITY_EN
            parReg    <= parNext;
`endif
        end
    end

    // Next-state logic: the next bit's level is decided on the last cycle of
    // the current bit so that tx and bitStrobe change together on counter 0.
    always_comb begin
        stateNext  = state;
        cntNext    = cnt;
        idxNext    = bitIdx;
        shiftNext  = shiftReg;
        txNext     = tx;
        strobeNext = 1'b0;
`ifdef SERIAL_SET_PERIOD_TX_PARITY_EN
        parNext    = parReg;
`endif
        if (state == IDLE) begin
            txNext  = 1'b0;
            cntNext = '0;
            idxNext = '0;
            if (dataValid && dataReady) begin
                stateNext  = PREAMBLE;
                shiftNext  = dataIn;
                txNext     = 1'b1;
                strobeNext = 1'b1;
`ifdef SERIAL_SET_PERIOD_TX_PARITY_EN
                parNext    = ^dataIn;
`endif
            end
        end else if (cnt != CNT_LAST) begin
            cntNext = cnt + 1'b1;
        end else begin
            cntNext    = '0;
            strobeNext = 1'b1;
            case (state)
                PREAMBLE: begin
                    if (bitIdx == PRE_LAST) begin
                        stateNext = START;
                        idxNext   = '0;
                        txNext    = 1'b1;
                    end else begin
                        idxNext = bitIdx + 1'b1;
                        txNext  = ~tx;
                    end
                end
                START: begin
                    if (bitIdx == IDX_W'(1)) begin
                        stateNext = DATA;
                        idxNext   = '0;
                        txNext    = shiftReg[DATA_WIDTH-1];
                        shiftNext = shiftReg << 1;
                    end else begin
                        idxNext = bitIdx + 1'b1;
                        txNext  = 1'b1;
                    end
                end
                DATA: begin
                    if (bitIdx == DAT_LAST) begin
                        idxNext = '0;
`ifdef SERIAL_SET_PERIOD_TX_PARITY_EN
                        stateNext = PARITY;
                        txNext    = parReg;
`else
                        stateNext = STOP;
                        txNext    = 1'b0;
`endif
                    end else begin
                        idxNext   = bitIdx + 1'b1;
                        txNext    = shiftReg[DATA_WIDTH-1];
                        shiftNext = shiftReg << 1;
                    end
                end
`ifdef SERIAL_SET_PERIOD_TX_PARITY_EN
                PARITY: begin
                    stateNext = STOP;
                    txNext    = 1'b0;
                end
`endif
                default: begin
                    // End of STOP (or an unreachable code): back to IDLE quietly.
                    stateNext  = IDLE;
                    txNext     = 1'b0;
                    strobeNext = 1'b0;
                end
            endcase
        end
        readyNext = (stateNext == IDLE);
    end

endmodule

// File: tb/tb_serial_set_period_tx.sv
// Bench for serial_set_period_tx: default instance plus a minimal
// TARGET_PERIOD=2 / DATA_WIDTH=1 / PREAMBLE_BITS=2 instance.
module tb_serial_set_period_tx;

`ifdef SERIAL_SET_PERIOD_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic       clk, rst_n;
    logic [7:0] dataIn;
    logic       dataValid, dataReady, tx, bitStrobe, busy;
    logic [0:0] sDataIn;
    logic       sValid, sReady, sTx, sStrobe, sBusy;

    int checks = 0;
    int errors = 0;

    serial_set_period_tx dut (
        .clk(clk), .rst_n(rst_n), .dataIn(dataIn), .dataValid(dataValid),
        .dataReady(dataReady), .tx(tx), .bitStrobe(bitStrobe), .busy(busy)
    );

    serial_set_period_tx #(.TARGET_PERIOD(2), .DATA_WIDTH(1), .PREAMBLE_BITS(2)) dutS (
        .clk(clk), .rst_n(rst_n), .dataIn(sDataIn), .dataValid(sValid),
        .dataReady(sReady), .tx(sTx), .bitStrobe(sStrobe), .busy(sBusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: frame described as a list of bit levels.
    function automatic int frameBits(input int pb, input int dw);
        return pb + 2 + dw + P + 1;
    endfunction

    function automatic logic expBit(input int pb, input int dw, input logic [31:0] d, input int k);
        logic par;
        par = 1'b0;
        for (int i = 0; i < dw; i++) par = par ^ d[i];
        if (k < pb) return (k % 2 == 0);
        k = k - pb;
        if (k < 2) return 1'b1;
        k = k - 2;
        if (k < dw) return d[dw-1-k];
        k = k - dw;
        if (P == 1 && k == 0) return par;
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic waitReady();
        int n = 0;
        while (dataReady !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("readyTimeout", dataReady, 1);
    endtask

    // Called at a negedge with dataValid=1 and dataIn=d already driven.
    task automatic runFrame(input logic [7:0] d, input bit toggle, input bit hold, input logic [7:0] nextD);
        int nb = frameBits(8, 8);
        int strobes = 0;
        int busyCyc = 0;
        for (int c = 0; c < nb * 10; c++) begin
            @(negedge clk);
            chk("tx", tx, expBit(8, 8, d, c / 10));
            chk("strobe", bitStrobe, (c % 10 == 0));
            chk("busy", busy, 1);
            chk("readyLow", dataReady, 0);
            strobes += bitStrobe;
            busyCyc += busy;
            if (c == 0) begin
                if (hold) dataIn = nextD;
                else dataValid = 1'b0;
            end
            if (toggle) dataIn = 8'($urandom);
        end
        chk("strobeCount", strobes, nb);
        chk("busyCycles", busyCyc, nb * 10);
        @(negedge clk);
        chk("idleBusy", busy, 0);
        chk("idleTx", tx, 0);
        chk("idleStrobe", bitStrobe, 0);
        chk("idleReady", dataReady, 1);
    endtask

    initial begin
        logic [7:0] rd;
        bit         rt;
        int         nbS;
        rst_n = 1'b1; dataValid = 1'b0; dataIn = '0; sValid = 1'b0; sDataIn = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("rstTx", tx, 0);
        chk("rstBusy", busy, 0);
        chk("rstStrobe", bitStrobe, 0);
        chk("rstReady", dataReady, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("readyAfterRst", dataReady, 1);
        chk("sReadyAfterRst", sReady, 1);

        // Directed payloads, then one with dataIn churning mid-frame.
        dataIn = 8'hA5; dataValid = 1'b1; runFrame(8'hA5, 1'b0, 1'b0, 8'h00);
        dataIn = 8'h07; dataValid = 1'b1; runFrame(8'h07, 1'b0, 1'b0, 8'h00);
        dataIn = 8'h5A; dataValid = 1'b1; runFrame(8'h5A, 1'b1, 1'b0, 8'h00);

        for (int r = 0; r < 4; r++) begin
            rd = 8'($urandom);
            rt = 1'($urandom);
            waitReady();
            dataIn = rd; dataValid = 1'b1;
            runFrame(rd, rt, 1'b0, 8'h00);
        end

        // Back-to-back: valid held, second word taken after one IDLE cycle.
        waitReady();
        dataIn = 8'h3C; dataValid = 1'b1;
        runFrame(8'h3C, 1'b0, 1'b1, 8'hC3);
        runFrame(8'hC3, 1'b0, 1'b0, 8'h00);

        // Reset in the middle of a frame.
        dataIn = 8'hFF; dataValid = 1'b1;
        @(negedge clk);
        dataValid = 1'b0;
        repeat (57) @(negedge clk);
        chk("busyBeforeRst", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midRstTx", tx, 0);
        chk("midRstBusy", busy, 0);
        chk("midRstStrobe", bitStrobe, 0);
        chk("midRstReady", dataReady, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("readyAfterMidRst", dataReady, 1);
        chk("busyAfterMidRst", busy, 0);
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            chk("residualTx", tx, 0);
            chk("residualStrobe", bitStrobe, 0);
        end

        // Minimal-parameter instance.
        nbS = frameBits(2, 1);
        sDataIn = 1'b1; sValid = 1'b1;
        for (int c = 0; c < nbS * 2; c++) begin
            @(negedge clk);
            chk("sTx", sTx, expBit(2, 1, 32'd1, c / 2));
            chk("sStrobe", sStrobe, (c % 2 == 0));
            chk("sBusy", sBusy, 1);
            if (c == 0) sValid = 1'b0;
        end
        @(negedge clk);
        chk("sIdleBusy", sBusy, 0);
        chk("sIdleTx", sTx, 0);
        chk("sIdleReady", sReady, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
